// File: rtl/axis_adc_decimator_pkg.sv
// Shared helpers for the ADC boxcar decimator: status widths and saturating counter step.
package axis_adc_decimator_pkg;

  localparam int unsigned StsDropsWidth = 32;

  function automatic logic [StsDropsWidth-1:0] sat_inc(input logic [StsDropsWidth-1:0] v);
    return (v == '1) ? v : v + StsDropsWidth'(1);
  endfunction

endpackage

// File: rtl/axis_adc_decimator_outreg.sv
// One-deep AXI4-Stream output register. A result arriving while the register is full
// and not draining is dropped and counted.
module axis_adc_decimator_outreg
  import axis_adc_decimator_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     res_valid,
  input  logic [ACC_WIDTH-1:0]     res_data,
  output logic [ACC_WIDTH-1:0]     m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     sts_overrun,
  output logic [StsDropsWidth-1:0] sts_drops
);

  logic [ACC_WIDTH-1:0]     tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;
  logic                     overrun_q, overrun_d;
  logic [StsDropsWidth-1:0] drops_q, drops_d;
  logic                     pop;

  always_comb begin
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    overrun_d = overrun_q;
    drops_d   = drops_q;
    pop       = tvalid_q && m_axis_tready;
    if (res_valid) begin
      if (!tvalid_q || pop) begin
        tdata_d  = res_data;
        tvalid_d = 1'b1;
      end else begin
        // Held beat must stay stable on the bus, so the new result is the one lost.
        overrun_d = 1'b1;
        drops_d   = sat_inc(drops_q);
      end
    end else if (pop) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      drops_q   <= '0;
    end else begin
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      overrun_q <= overrun_d;
      drops_q   <= drops_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign sts_overrun   = overrun_q;
  assign sts_drops     = drops_q;

endmodule

// File: rtl/axis_adc_decimator.sv
// Boxcar decimator for the free-running ADC stream: sums R samples, shifts, and offers
// each block result to a one-deep AXI4-Stream output that drops on overrun.
module axis_adc_decimator
  import axis_adc_decimator_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH        = 32,
  parameter int unsigned CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [CNTR_WIDTH-1:0]       cfg_ratio,
  input  logic [4:0]                  cfg_shift,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic [ACC_WIDTH-1:0]        m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        sts_overrun,
  output logic [StsDropsWidth-1:0]    sts_drops
);

  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0] r_lat_q, r_cfg, r_eff;
  logic [4:0]            s_lat_q, s_eff;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  sample_ext, sum, res_data;
  logic                  start_q;
  logic                  frame_end;

  // Config is sampled only in the first cycle of a frame, so it also steers that cycle.
  always_comb begin
    r_cfg      = (cfg_ratio == '0) ? CNTR_WIDTH'(1) : cfg_ratio;
    r_eff      = start_q ? r_cfg : r_lat_q;
    s_eff      = start_q ? cfg_shift : s_lat_q;
    sample_ext = {{(ACC_WIDTH - AXIS_TDATA_WIDTH){s_axis_tdata[AXIS_TDATA_WIDTH-1]}},
                  s_axis_tdata};
    sum        = acc_q + sample_ext;
    res_data   = $signed(sum) >>> s_eff;
    frame_end  = s_axis_tvalid && (cnt_q == r_eff - CNTR_WIDTH'(1));
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    if (frame_end) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (s_axis_tvalid) begin
      cnt_d = cnt_q + CNTR_WIDTH'(1);
      acc_d = sum;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      r_lat_q <= r_cfg;
      s_lat_q <= cfg_shift;
      start_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      start_q <= frame_end;
      if (start_q) begin
        r_lat_q <= r_cfg;
        s_lat_q <= cfg_shift;
      end
    end
  end

  axis_adc_decimator_outreg #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_outreg (
    .aclk          (aclk),
    .areset        (areset),
    .res_valid     (frame_end),
    .res_data      (res_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_overrun   (sts_overrun),
    .sts_drops     (sts_drops)
  );

endmodule

// File: tb/tb_axis_adc_decimator.sv
// Self-checking bench for axis_adc_decimator: vector table plus corner-case sequences,
// with a queue scoreboard fed at stimulus time and drained at each output handshake.
module tb_axis_adc_decimator;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] cfg_ratio;
  logic [4:0]  cfg_shift;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        sts_overrun;
  logic [31:0] sts_drops;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          ratio;
    int          shift;
    int          n;
    int          samp[8];
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  always #5 aclk = ~aclk;

  axis_adc_decimator #(
    .AXIS_TDATA_WIDTH(16),
    .ACC_WIDTH       (32),
    .CNTR_WIDTH      (16)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_ratio     (cfg_ratio),
    .cfg_shift     (cfg_shift),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_overrun   (sts_overrun),
    .sts_drops     (sts_drops)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the edge and are steady until the next one,
  // so the negedge view is exactly what the next posedge will see.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h, expected no output", m_axis_tdata);
      end else begin
        check("scoreboard", m_axis_tdata, exp_q.pop_front());
      end
    end
  end

  task automatic beat(input int s);
    @(posedge aclk);
    #1;
    s_axis_tdata  = 16'(s);
    s_axis_tvalid = 1'b1;
  endtask

  task automatic idle();
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset(input int r, input int sh);
    @(posedge aclk);
    #1;
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    cfg_ratio     = 16'(r);
    cfg_shift     = 5'(sh);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4, 2,  4, '{1, 2, 3, 4, 0, 0, 0, 0},                32'h0000_0002};
    vecs[1] = '{2, 0,  2, '{-32768, -32768, 0, 0, 0, 0, 0, 0},      32'hFFFF_0000};
    vecs[2] = '{3, 1,  3, '{-5, 7, -9, 0, 0, 0, 0, 0},              32'hFFFF_FFFC};
    vecs[3] = '{4, 0,  4, '{32767, 32767, 32767, 32767, 0, 0, 0, 0}, 32'h0001_FFFC};
    vecs[4] = '{0, 0,  1, '{-1, 0, 0, 0, 0, 0, 0, 0},               32'hFFFF_FFFF};
    vecs[5] = '{2, 4,  2, '{100, -3, 0, 0, 0, 0, 0, 0},             32'h0000_0006};
    vecs[6] = '{8, 3,  8, '{1, 2, 3, 4, 5, 6, 7, 8},                32'h0000_0004};
    vecs[7] = '{1, 31, 1, '{-2, 0, 0, 0, 0, 0, 0, 0},               32'hFFFF_FFFF};
    vecs[8] = '{1, 31, 1, '{5, 0, 0, 0, 0, 0, 0, 0},                32'h0000_0000};

    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    cfg_ratio     = 16'd1;
    cfg_shift     = 5'd0;

    do_reset(vecs[0].ratio, vecs[0].shift);
    check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("reset_tdata", m_axis_tdata, 32'd0);
    check("reset_overrun", 32'(sts_overrun), 32'd0);
    check("reset_drops", sts_drops, 32'd0);

    // Next vector's config is applied in the frame-start cycle after each frame.
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        if (j == vecs[i].n - 1) exp_q.push_back(vecs[i].exp);
        beat(vecs[i].samp[j]);
      end
      idle();
      if (i + 1 < 9) begin
        cfg_ratio = 16'(vecs[i+1].ratio);
        cfg_shift = 5'(vecs[i+1].shift);
      end
    end
    repeat (3) idle();
    check("table_drained", 32'(exp_q.size()), 32'd0);

    // Latency and single-cycle valid pulse.
    do_reset(4, 2);
    beat(1);
    beat(2);
    beat(3);
    exp_q.push_back(32'd2);
    beat(4);
    idle();
    check("lat_tvalid_t1", 32'(m_axis_tvalid), 32'd1);
    check("lat_tdata_t1", m_axis_tdata, 32'd2);
    idle();
    check("lat_tvalid_t2", 32'(m_axis_tvalid), 32'd0);

    // R=1 pass-through ramp.
    do_reset(1, 0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(32'(i));
      beat(i);
    end
    idle();
    idle();
    check("ramp_drops", sts_drops, 32'd0);
    check("ramp_overrun", 32'(sts_overrun), 32'd0);

    // Backpressure: first result held, later ones dropped.
    do_reset(2, 0);
    m_axis_tready = 1'b0;
    exp_q.push_back(32'd3);
    for (int i = 1; i <= 6; i++) beat(i);
    check("hold_tdata_mid", m_axis_tdata, 32'd3);
    check("hold_drops_mid", sts_drops, 32'd1);
    beat(7);
    beat(8);
    idle();
    check("hold_tdata_end", m_axis_tdata, 32'd3);
    check("hold_tvalid_end", 32'(m_axis_tvalid), 32'd1);
    check("drops_count", sts_drops, 32'd3);
    check("overrun_sticky", 32'(sts_overrun), 32'd1);
    m_axis_tready = 1'b1;
    idle();
    check("drain_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("overrun_stays", 32'(sts_overrun), 32'd1);

    // Mid-frame ratio change only affects later frames.
    do_reset(4, 0);
    beat(1);
    beat(2);
    cfg_ratio = 16'd2;
    beat(3);
    exp_q.push_back(32'd10);
    beat(4);
    beat(5);
    exp_q.push_back(32'd11);
    beat(6);
    beat(7);
    exp_q.push_back(32'd15);
    beat(8);
    repeat (3) idle();
    check("ratio_change_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with a pending output.
    do_reset(4, 0);
    m_axis_tready = 1'b0;
    beat(10);
    beat(20);
    beat(30);
    beat(40);
    beat(1);
    beat(2);
    beat(3);
    @(posedge aclk);
    #1;
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    check("pre_reset_pending", 32'(m_axis_tvalid), 32'd1);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    check("midreset_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midreset_drops", sts_drops, 32'd0);
    m_axis_tready = 1'b1;
    beat(5);
    beat(6);
    beat(7);
    exp_q.push_back(32'd26);
    beat(8);
    idle();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge aclk);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
